// File: rtl/psum_accumulator_if.sv
// Bundle of the product stream, the external adder link and the result handshake.
// The accumulator takes the slave side; the environment (source, adder, sink) takes the master side.
interface psum_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_y;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  modport slave (
    input  in_valid, in_data, add_y, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, add_y, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/psum_accumulator.sv
// Folds a window of LEN product terms into one saturating 16-bit partial sum using an
// external combinational adder, then offers the sum downstream over valid/ready.
module psum_accumulator #(
  parameter int unsigned LEN = 9
) (
  input logic               clk,
  input logic               rst_n,
  psum_accumulator_if.slave bus
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(LEN - 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e        state;
  logic [15:0]   acc;
  logic [CW-1:0] cnt;
  logic          sat;

  // Masking acc on the first term starts a fresh window without clearing acc on handoff.
  assign bus.add_a     = (cnt == '0) ? 16'h0000 : acc;
  assign bus.add_b     = bus.in_data;
  assign bus.in_ready  = (state == StAccum);
  assign bus.out_valid = (state == StHold);
  assign bus.out_data  = acc;
  assign bus.out_sat   = sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StAccum;
      acc   <= 16'h0000;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      unique case (state)
        StAccum: begin
          if (bus.in_valid) begin
            // Sticky saturation only counts within the current window.
            if ((sat && (cnt != '0)) || bus.add_cout) begin
              acc <= 16'hFFFF;
              sat <= 1'b1;
            end else begin
              acc <= bus.add_y;
              if (cnt == '0) begin
                sat <= 1'b0;
              end
            end
            if (cnt == LastCnt) begin
              cnt   <= '0;
              state <= StHold;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state <= StAccum;
          end
        end
        default: state <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a window-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_psum_accumulator;
  localparam int unsigned LEN = 9;

  logic clk;
  logic rst_n;
  bit   approx;
  int   total;
  int   bad;

  psum_accumulator_if bus ();

  psum_accumulator #(.LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: exact, or an approximate stub that drops sum bit 0 (carry stays exact).
  logic [16:0] sum17;
  always_comb begin
    sum17        = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    bus.add_y    = sum17[15:0];
    if (approx) bus.add_y[0] = 1'b0;
    bus.add_cout = sum17[16];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Window result from its term list: {sat, sum}.
  function automatic logic [16:0] fold(input logic [15:0] terms[$], input bit apx);
    logic [15:0] a;
    logic        s;
    logic [16:0] t;
    a = 16'h0000;
    s = 1'b0;
    foreach (terms[i]) begin
      t = {1'b0, a} + {1'b0, terms[i]};
      if (s || t[16]) begin
        a = 16'hFFFF;
        s = 1'b1;
      end else begin
        a = t[15:0];
        if (apx) a[0] = 1'b0;
      end
    end
    return {s, a};
  endfunction

  logic [15:0] m_terms[$];
  logic [16:0] m_prev = '0;
  bit          m_hold = 1'b0;

  // Compare against the model at the falling edge, then advance it with the inputs the
  // DUT will see at the next rising edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      m_terms.delete();
      m_prev = '0;
      m_hold = 1'b0;
    end
    e = (m_terms.size() > 0) ? fold(m_terms, approx) : m_prev;
    chk("m_in_ready", bus.in_ready, !m_hold);
    chk("m_out_valid", bus.out_valid, m_hold);
    chk("m_out_data", bus.out_data, e[15:0]);
    chk("m_out_sat", bus.out_sat, e[16]);
    chk("m_add_a", bus.add_a, (m_terms.size() > 0) ? e[15:0] : 16'h0000);
    chk("m_add_b", bus.add_b, bus.in_data);
    if (rst_n) begin
      if (m_hold) begin
        if (bus.out_ready) m_hold = 1'b0;
      end else if (bus.in_valid) begin
        m_terms.push_back(bus.in_data);
        if (m_terms.size() == LEN) begin
          m_prev = fold(m_terms, approx);
          m_terms.delete();
          m_hold = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] t);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = t;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", bus.in_ready, 1'b1);
    step();
  endtask

  task automatic chk_out(input string name, input logic [15:0] d, input logic s);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk({name, "_data"}, bus.out_data, d);
    chk({name, "_sat"}, bus.out_sat, s);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    approx        = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_out_sat", bus.out_sat, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Terms 1..9 back to back.
    for (int i = 1; i <= 9; i++) send(16'(i));
    bus.in_valid = 1'b0;
    chk_out("seq", 16'h002D, 1'b0);
    chk("seq_in_ready_hold", bus.in_ready, 1'b0);
    step();
    chk("seq_one_cycle", bus.out_valid, 1'b0);
    chk("seq_kept_acc", bus.out_data, 16'h002D);
    chk("seq_add_a_masked", bus.add_a, 16'h0000);

    // Overflow, then backpressure with ignored in_valid pulses.
    bus.out_ready = 1'b0;
    send(16'hF000);
    send(16'h2000);
    for (int i = 0; i < 7; i++) send(16'h0001);
    chk_out("ovf", 16'hFFFF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      bus.in_data  = 16'h0055;
      step();
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk_out("bp", 16'hFFFF, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_released", bus.out_valid, 1'b0);
    for (int i = 0; i < 9; i++) send(16'h0002);
    bus.in_valid = 1'b0;
    chk_out("sat_clear", 16'h0012, 1'b0);
    step();

    // Input bubbles.
    for (int i = 1; i <= 9; i++) begin
      send(16'(i));
      bus.in_valid = 1'b0;
      if (i < 9) step();
    end
    chk_out("bubble", 16'h002D, 1'b0);
    step();

    // Reset mid-window.
    for (int i = 0; i < 4; i++) send(16'h0005);
    bus.in_valid = 1'b0;
    chk("pre_rst_acc", bus.out_data, 16'h0014);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", bus.out_data, 16'h0000);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 9; i++) send(16'h0001);
    bus.in_valid = 1'b0;
    chk_out("post_rst", 16'h0009, 1'b0);
    step();

    // Approximate adder stub: every partial sum loses bit 0.
    approx = 1'b1;
    for (int i = 0; i < 9; i++) send(16'h0003);
    bus.in_valid = 1'b0;
    chk_out("approx", 16'h0012, 1'b0);
    step();
    approx = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
